// File: rtl/fft256_output_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order using ping-pong banks.
// Bin 0 appears two edges after the last sample is captured; there is no backpressure, frames stream back-to-back.
module fft256_output_reorder #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int N = 1 << LOG2N;

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  logic [2*WIDTH-1:0] bank0 [N];
  logic [2*WIDTH-1:0] bank1 [N];
  logic [2*WIDTH-1:0] rd_word;

  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] rcnt;
  logic             wbank;
  logic             rbank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_last;
  logic             rd_last;
  state_t           state;
  state_t           state_nxt;

  assign wr_last = di_en && (wcnt == LOG2N'(N-1));

  // Unreset storage; the write address scatters samples to their natural bin slot.
  always_ff @(posedge clock) begin
    if (di_en) begin
      if (wbank) bank1[bitrev(wcnt)] <= {di_re, di_im};
      else       bank0[bitrev(wcnt)] <= {di_re, di_im};
    end
  end

  assign rd_word = rbank ? bank1[rcnt] : bank0[rcnt];

  always_comb begin
    state_nxt = state;
    rd_last   = 1'b0;
    case (state)
      IDLE: if (full[rbank]) state_nxt = READ;
      READ: begin
        if (rcnt == LOG2N'(N-1)) begin
          rd_last   = 1'b1;
          state_nxt = full[~rbank] ? READ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear before set so a writer completion and reader release in one cycle both land.
  always_comb begin
    full_nxt = full;
    if (rd_last) full_nxt[rbank] = 1'b0;
    if (wr_last) full_nxt[wbank] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
      rcnt  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= '0;
      do_en <= 1'b0;
      do_re <= '0;
      do_im <= '0;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;
      if (di_en)   wcnt  <= wcnt + LOG2N'(1);
      if (wr_last) wbank <= ~wbank;
      if (rd_last) rbank <= ~rbank;
      if (state == READ) rcnt <= rcnt + LOG2N'(1);
      else               rcnt <= '0;
      do_en <= (state == READ);
      do_re <= (state == READ) ? rd_word[2*WIDTH-1:WIDTH] : '0;
      do_im <= (state == READ) ? rd_word[WIDTH-1:0]       : '0;
    end
  end

endmodule

// File: tb/tb_fft256_output_reorder.sv
// Bench for fft256_output_reorder: frame-level reference schedule plus directed corner sequences.
module tb_fft256_output_reorder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        di_en = 1'b0;
  logic [15:0] di_re = '0;
  logic [15:0] di_im = '0;
  logic        do_en;
  logic [15:0] do_re;
  logic [15:0] do_im;

  fft256_output_reorder #(.WIDTH(16), .LOG2N(8)) dut (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int brev8(input int x);
    int r = 0;
    for (int i = 0; i < 8; i++) r = r * 2 + ((x >> i) & 1);
    return r;
  endfunction

  // Reference: each completed frame schedules 256 natural-order bins from cycle E+2 onwards.
  longint      cyc = 0;
  longint      next_free = 0;
  logic [31:0] exp_map [longint];
  logic [15:0] pre [256];
  logic [15:0] pim [256];
  int          pcnt = 0;

  always @(posedge clock) begin
    longint st;
    cyc++;
    if (reset) begin
      pcnt = 0;
      exp_map.delete();
      next_free = 0;
    end else if (di_en) begin
      pre[pcnt] = di_re;
      pim[pcnt] = di_im;
      pcnt++;
      if (pcnt == 256) begin
        st = (cyc + 2 > next_free) ? cyc + 2 : next_free;
        for (int k = 0; k < 256; k++) exp_map[st + k] = {pre[brev8(k)], pim[brev8(k)]};
        next_free = st + 256;
        pcnt = 0;
      end
    end
  end

  logic [31:0] obs [$];
  int          runlen = 0;
  int          lastrun = 0;

  always @(negedge clock) begin
    logic        exp_en;
    logic [31:0] ew;
    if (reset) begin
      chk("rst_do_en", {31'b0, do_en}, 32'd0);
      chk("rst_do_re", {16'b0, do_re}, 32'd0);
      chk("rst_do_im", {16'b0, do_im}, 32'd0);
    end else begin
      exp_en = exp_map.exists(cyc);
      ew     = exp_en ? exp_map[cyc] : 32'd0;
      chk("do_en", {31'b0, do_en}, {31'b0, exp_en});
      chk("do_re", {16'b0, do_re}, {16'b0, ew[31:16]});
      chk("do_im", {16'b0, do_im}, {16'b0, ew[15:0]});
    end
    if (do_en) begin
      obs.push_back({do_re, do_im});
      runlen++;
    end else begin
      if (runlen != 0) lastrun = runlen;
      runlen = 0;
    end
  end

  typedef struct {
    int          m;
    logic [15:0] re;
    logic [15:0] im;
  } vec_t;
  vec_t tbl [6];

  task automatic send(input logic [15:0] re, input logic [15:0] im, input int gap);
    repeat (gap) begin
      @(negedge clock);
      di_en = 1'b0;
    end
    @(negedge clock);
    di_en = 1'b1;
    di_re = re;
    di_im = im;
  endtask

  task automatic ramp(input int offset, input int gap);
    for (int n = 0; n < 256; n++) send(16'(n + offset), 16'(255 - n), (n == 0) ? 0 : gap);
  endtask

  task automatic drain();
    int b = 0;
    repeat (2) begin
      @(negedge clock);
      di_en = 1'b0;
    end
    while ((cyc <= next_free || do_en) && b < 4000) begin
      @(negedge clock);
      b++;
    end
    repeat (2) @(negedge clock);
    chk("drain_bound", {31'b0, b >= 4000}, 32'd0);
  endtask

  task automatic check_ramp(input string nm, input int base, input int off);
    for (int i = 0; i < 6; i++)
      chk({nm, "_bin"}, obs[base + off + tbl[i].m], {tbl[i].re + 16'(off), tbl[i].im});
  endtask

  task automatic do_reset();
    @(negedge clock);
    di_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_en", {31'b0, do_en}, 32'd0);
    chk("async_rst_re", {16'b0, do_re}, 32'd0);
    chk("async_rst_im", {16'b0, do_im}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int b;
    int same;
    tbl[0] = '{0, 16'd0, 16'd255};
    tbl[1] = '{1, 16'd128, 16'd127};
    tbl[2] = '{2, 16'd64, 16'd191};
    tbl[3] = '{255, 16'd255, 16'd0};
    tbl[4] = '{3, 16'd192, 16'd63};
    tbl[5] = '{128, 16'd1, 16'd254};

    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Single ramp frame
    base = obs.size();
    ramp(0, 0);
    drain();
    chk("ramp_count", 32'(obs.size() - base), 32'd256);
    check_ramp("ramp", base, 0);
    chk("ramp_run", 32'(lastrun), 32'd256);

    // Back-to-back frames, no gap
    base = obs.size();
    ramp(0, 0);
    ramp(256, 0);
    drain();
    chk("b2b_run", 32'(lastrun), 32'd512);
    check_ramp("b2b_f1", base, 0);
    check_ramp("b2b_f2", base, 256);

    // Gapped input
    base = obs.size();
    ramp(0, 1);
    drain();
    chk("gap_count", 32'(obs.size() - base), 32'd256);
    check_ramp("gap", base, 0);
    chk("gap_run", 32'(lastrun), 32'd256);

    // Reset mid-write
    for (int n = 0; n < 100; n++) send(16'hAAAA, 16'h5555, 0);
    do_reset();
    base = obs.size();
    ramp(0, 0);
    drain();
    chk("rstw_count", 32'(obs.size() - base), 32'd256);
    check_ramp("rstw", base, 0);

    // Reset mid-read at output m=50
    base = obs.size();
    ramp(0, 0);
    @(negedge clock);
    di_en = 1'b0;
    b = 0;
    while (obs.size() - base < 50 && b < 1000) begin
      @(negedge clock);
      #1;
      b++;
    end
    chk("rstr_reach50", 32'(obs.size() - base), 32'd50);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rstr_en", {31'b0, do_en}, 32'd0);
    chk("rstr_re", {16'b0, do_re}, 32'd0);
    chk("rstr_im", {16'b0, do_im}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (300) @(negedge clock);
    chk("rstr_silent", 32'(obs.size() - base), 32'd50);
    base = obs.size();
    ramp(0, 0);
    drain();
    check_ramp("rstr_new", base, 0);

    // Extremes
    base = obs.size();
    for (int n = 0; n < 256; n++) send(16'h7FFF, 16'h8000, 0);
    drain();
    same = 0;
    for (int i = base; i < obs.size(); i++) if (obs[i] == 32'h7FFF8000) same++;
    chk("ext_bits", 32'(same), 32'd256);

    // Randomized frames with random gaps, checked cycle-by-cycle by the reference
    for (int f = 0; f < 3; f++)
      for (int n = 0; n < 256; n++)
        send(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft256_output_reorder.md
Name: fft256_output_reorder

Overview:
- Sits directly downstream of the 256-point FFT pipeline (last stage, Stage8).
- Takes complex samples in the pipeline's bit-reversed output order and re-emits each 256-sample frame in natural bin order (X[0]..X[255]).
- Uses a ping-pong pair of 256-entry complex buffers, so frames can stream back-to-back with no backpressure.

Parameters:
- WIDTH, 16, bit width of each real and each imaginary sample.
- LOG2N, 8, log2 of the frame length. The frame length N = 2^LOG2N = 256. Only 8 is required to be supported.

Ports:
- clock  input  1  Master clock; all logic rises on the posedge.
- reset  input  1  Asynchronous, active-high reset.
- di_en  input  1  Input data enable; one sample is accepted per cycle while high.
- di_re  input  WIDTH  Input sample, real part; the n-th accepted sample of a frame is X[bitrev8(n)].
- di_im  input  WIDTH  Input sample, imaginary part.
- do_en  output  1  Output data enable; high for exactly 256 consecutive cycles per frame.
- do_re  output  WIDTH  Output bin, real part; natural order.
- do_im  output  WIDTH  Output bin, imaginary part.

Behaviour:
- Storage:
  - Two banks, bank0 and bank1, each 256 x (2*WIDTH).
  - RAM contents are not reset.
  - Synchronous-read memory is acceptable; the latency below already accounts for it.
- Write side:
  - 8-bit counter wcnt plus a write-bank pointer wbank.
  - On a clock edge with di_en=1: write {di_re,di_im} to bank[wbank] at address bitrev8(wcnt), then increment wcnt.
  - When wcnt wraps from 255 to 0: set full[wbank]=1 and toggle wbank.
  - Gaps in di_en are allowed anywhere; wcnt holds while di_en=0.
- Read side FSM, states IDLE and READ:
  - IDLE -> READ when full[rbank]=1. Clear rcnt to 0.
  - READ: issue read address rcnt from bank[rbank] and increment rcnt every cycle, unconditionally.
  - When rcnt=255 is issued: clear full[rbank], toggle rbank, and go back to IDLE. If full of the new rbank is already 1, go straight into READ with no idle cycle.
- Latency:
  - Let edge E be the one that captures sample n=255 of a frame.
  - Output bin 0 is presented on do_* after edge E+2.
  - Bins 1..255 follow on consecutive cycles, with do_en=1 continuously for 256 cycles.
- No overflow possible:
  - The reader drains 256 entries in 256 cycles, and the writer needs at least 256 cycles to fill the other bank.
  - Therefore a bank is never rewritten while it is being read.
  - A simultaneous full-set (writer) and full-clear (reader) on different banks in the same cycle must both take effect.
- Output formatting: do_re and do_im are registered and are forced to 0 whenever do_en=0.
- Reset (asynchronous, any time):
  - Clears wcnt, rcnt, wbank, rbank, both full flags, the FSM (-> IDLE), do_en=0, do_re=0, do_im=0.
  - A partially written frame is discarded; a frame being read is truncated immediately.
  - After release, the first 256 accepted inputs form frame 0 again.
- No arithmetic or scaling: data passes through bit-exact.

Test Plan:
- Ramp frame: di_re=n, di_im=255-n for n=0..255, di_en continuous -> do_en rises 2 cycles after the last input and stays high 256 cycles; output m gives do_re=bitrev8(m), do_im=255-bitrev8(m). Checks: m=0 -> 0/255, m=1 -> 128/127, m=2 -> 64/191, m=255 -> 255/0.
- Back-to-back frames: two ramp frames, the second offset by +256 in di_re, with no gap -> 512 consecutive do_en=1 cycles; frame-2 output m has do_re=256+bitrev8(m); no idle cycle between frames.
- Gapped input: same ramp with di_en toggling 1,0,1,0 -> output identical to the first scenario; do_en starts 2 cycles after the 256th accepted sample and is continuous.
- Reset mid-write: assert reset after 100 accepted samples, release, then send a full ramp -> the output equals the first scenario exactly, with no output from the truncated frame.
- Reset mid-read: assert reset at output m=50 -> do_en, do_re and do_im read 0 immediately (asynchronously); nothing further is emitted until a new complete frame is accepted.
- Extremes: di_re=0x7FFF and di_im=0x8000 for all n -> all 256 outputs are 0x7FFF/0x8000 bit-exact; do_re/do_im are 0 on every cycle with do_en=0.
